// File: rtl/breg_file.sv
// breg_file - banked scratch-register file with masked overwrite/XOR writes,
// lower-to-upper half mirroring, a one-stage commit pipeline and a
// multi-cycle clear sequencer.
//
// Parameters:
//   WIDTH  entry width in bits (defaults to `BITNESS, 16 when not defined)
//   DEPTH  entry count, power of two, >= 4
//   NREAD  number of combinational read ports
//   AW     address width, derived from DEPTH
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   ra, rval     read addresses / data, port k at [k*AW +: AW] / [k*WIDTH +: WIDTH]
//   w, y, wa     write request, mode (1 = overwrite, 0 = XOR), address
//   wval, mask   write data, per-bit enable
//   w_rdy        write accepted when w && w_rdy (equals !busy)
//   clr, busy    clear-all request, clear sequencer active
//
// Handshake: a write is taken on a rising edge where w && w_rdy && !clr.
// clr is sampled only while !busy and beats a simultaneous write, which is
// dropped. While busy, w_rdy is low and clr is ignored.
//
// Build option: define BREG_BYPASS_EN to let the read ports see the pending
// write one edge earlier. Without it reads see only the committed array.

`ifndef BITNESS
`define BITNESS 16
`endif

module breg_file #(
  parameter  int WIDTH = `BITNESS,
  parameter  int DEPTH = 16,
  parameter  int NREAD = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREAD*AW-1:0]    ra,
  output logic [NREAD*WIDTH-1:0] rval,
  input  logic                   w,
  input  logic                   y,
  input  logic [AW-1:0]          wa,
  input  logic [WIDTH-1:0]       wval,
  input  logic [WIDTH-1:0]       mask,
  output logic                   w_rdy,
  input  logic                   clr,
  output logic                   busy
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic             pend_valid_q, pend_valid_d;
  logic [AW-1:0]    pend_addr_q,  pend_addr_d;
  logic [WIDTH-1:0] pend_data_q,  pend_data_d;

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q,   cnt_d;

  logic             w_acc;
  logic [WIDTH-1:0] old_val;
  logic [WIDTH-1:0] new_val;
  logic             pend_lower;
  logic [AW-1:0]    pend_mirror;

  assign busy  = (state_q == S_CLEAR);
  assign w_rdy = !busy;
  assign w_acc = w && !busy && !clr;

  // A lower-half pending entry also lands on its upper-half mirror.
  assign pend_lower  = !pend_addr_q[AW-1];
  assign pend_mirror = {1'b1, pend_addr_q[AW-2:0]};

  function automatic logic pend_hits(input logic [AW-1:0] a);
    return pend_valid_q &&
           ((pend_addr_q == a) || (pend_lower && (pend_mirror == a)));
  endfunction

  // Read-modify-write source: the pending stage is one edge ahead of the
  // array, so it must be forwarded to keep back-to-back writes exact.
  always_comb begin
    old_val = pend_hits(wa) ? pend_data_q : mem_q[wa];
    new_val = y ? wval : (old_val ^ wval);
  end

  always_comb begin
    pend_valid_d = w_acc;
    pend_addr_d  = wa;
    pend_data_d  = (old_val & ~mask) | (new_val & mask);
  end

  // Clear sequencer next-state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (clr) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == CNT_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Array next-state: pending commit (with mirror), then clear of entry cnt.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (pend_valid_q) begin
      mem_d[pend_addr_q] = pend_data_q;
      if (pend_lower) mem_d[pend_mirror] = pend_data_q;
    end
    if (busy) mem_d[cnt_q] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
    end
  end

  // Read ports.
  always_comb begin
    rval = '0;
    for (int k = 0; k < NREAD; k++) begin
      rval[k*WIDTH +: WIDTH] = mem_q[ra[k*AW +: AW]];
`ifdef BREG_BYPASS_EN
      if (pend_hits(ra[k*AW +: AW])) rval[k*WIDTH +: WIDTH] = pend_data_q;
`endif
    end
  end

endmodule
